// File: rtl/tabuleiro_pkg.sv
// Shared types for the LED-matrix battleship board: game phase and display layer.
package tabuleiro_pkg;

    typedef enum logic [1:0] {
        ST_SETUP    = 2'b00,
        ST_ATTACK   = 2'b01,
        ST_GAMEOVER = 2'b10
    } state_e;

    localparam logic VIEW_SHIPS   = 1'b0;
    localparam logic VIEW_ATTACKS = 1'b1;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modulo_varredura_colunas.sv
// Column scanner: a free-running divider advances the active column once per
// 2^SCAN_DIV clocks, cycling 0..COLS-1.
module modulo_varredura_colunas
    import tabuleiro_pkg::*;
#(
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 20,
    localparam int CW      = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          clr,
    output logic [CW-1:0] col_idx
);

    logic [SCAN_DIV-1:0] div_q, div_d;
    logic [CW-1:0]       col_q, col_d;
    logic                wrap;

    // Divider increment and column advance on divider wrap.
    always_comb begin
        div_d = div_q + 1'b1;
        wrap  = &div_q;
        col_d = col_q;
        if (wrap) begin
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    // Divider and column registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            div_q <= '0;
            col_q <= '0;
        end else begin
            div_q <= div_d;
            col_q <= col_d;
        end
    end

    assign col_idx = col_q;

endmodule

// File: rtl/modulo_tabuleiro_param.sv
// Battleship board on an LED matrix: ship placement, attack bookkeeping,
// hit/miss scoring and column-multiplexed display of either layer.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   SETUP     | waiting for a press to load ship_mask as the fleet
//   ATTACK    | each press fires at (coord_row, coord_col)
//   GAMEOVER  | every ship cell hit; a press wipes the board
//   (11)      | unreachable; falls back to SETUP on the next clock
module modulo_tabuleiro_param
    import tabuleiro_pkg::*;
#(
    parameter int ROWS     = 7,
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 20,
    localparam int RW      = idx_w(ROWS),
    localparam int CW      = idx_w(COLS),
    localparam int HW      = $clog2(ROWS * COLS + 1)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 btn,
    input  logic [ROWS*COLS-1:0] ship_mask,
    input  logic [RW-1:0]        coord_row,
    input  logic [CW-1:0]        coord_col,
    input  logic                 view,
    output logic [COLS-1:0]      m_col,
    output logic [ROWS-1:0]      m_line,
    output logic [1:0]           state,
    output logic                 hit,
    output logic                 miss,
    output logic                 rep,
    output logic                 err,
    output logic [HW-1:0]        hit_count,
    output logic [HW-1:0]        ships_left
);

    localparam int N = ROWS * COLS;

    state_e          state_q, state_d;
    logic            btn_q, btn_d;
    logic [N-1:0]    ship_q, ship_d;
    logic [N-1:0]    atk_q, atk_d;
    logic [HW-1:0]   hc_q, hc_d;
    logic [HW-1:0]   sl_q, sl_d;
    logic            hit_q, hit_d;
    logic            miss_q, miss_d;
    logic            rep_q, rep_d;
    logic            err_q, err_d;

    logic            press;
    logic            in_range;
    logic [N-1:0]    atk_sel;
    logic [HW-1:0]   pop;
    logic [CW-1:0]   col_idx;
    logic [N-1:0]    layer;
    logic [N-1:0]    col_bits;

    modulo_varredura_colunas #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_varredura (
        .clk     (clk),
        .clr     (clr),
        .col_idx (col_idx)
    );

    // State register: game phase, boards, counters, edge detector and pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_SETUP;
            btn_q   <= 1'b0;
            ship_q  <= '0;
            atk_q   <= '0;
            hc_q    <= '0;
            sl_q    <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            ship_q  <= ship_d;
            atk_q   <= atk_d;
            hc_q    <= hc_d;
            sl_q    <= sl_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
        end
    end

    // Next-state: press handling per phase, board updates and event pulses.
    always_comb begin
        press    = btn & ~btn_q;
        pop      = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + HW'(ship_mask[i]);
        end
        in_range = (int'(coord_row) < ROWS) && (int'(coord_col) < COLS);
        // Out-of-range shifts produce zero and are never used anyway.
        atk_sel  = N'(1) << (int'(coord_row) * COLS + int'(coord_col));

        state_d = state_q;
        btn_d   = btn;
        ship_d  = ship_q;
        atk_d   = atk_q;
        hc_d    = hc_q;
        sl_d    = sl_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        rep_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_SETUP: begin
                if (press) begin
                    if (pop != '0) begin
                        ship_d  = ship_mask;
                        atk_d   = '0;
                        hc_d    = '0;
                        sl_d    = pop;
                        state_d = ST_ATTACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ATTACK: begin
                if (press) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (|(atk_q & atk_sel)) begin
                        rep_d = 1'b1;
                    end else begin
                        atk_d = atk_q | atk_sel;
                        if (|(ship_q & atk_sel)) begin
                            hit_d = 1'b1;
                            if (hc_q != HW'(N)) hc_d = hc_q + 1'b1;
                            if (sl_q != '0)     sl_d = sl_q - 1'b1;
                            if (sl_q <= HW'(1)) state_d = ST_GAMEOVER;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
            end
            ST_GAMEOVER: begin
                if (press) begin
                    ship_d  = '0;
                    atk_d   = '0;
                    hc_d    = '0;
                    sl_d    = '0;
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_SETUP;
        endcase
    end

    // Display: selected layer sliced at the active column; parked on column 0 while clear is held.
    always_comb begin
        layer    = (view == VIEW_ATTACKS) ? atk_q : ship_q;
        col_bits = layer >> col_idx;
        m_col    = '0;
        m_line   = '0;
        if (clr) begin
            m_col[0] = 1'b1;
        end else begin
            m_col = COLS'(1) << col_idx;
            for (int r = 0; r < ROWS; r++) begin
                m_line[r] = col_bits[r*COLS];
            end
        end
    end

    assign state      = state_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign rep        = rep_q;
    assign err        = err_q;
    assign hit_count  = hc_q;
    assign ships_left = sl_q;

endmodule
